// File: rtl/youseios_pkg.sv
// rtl/youseios_pkg.sv - shared types and constants for the YouseiOS scheduler
//
// Purpose: PID width, scheduler state enum, ready-mask type and a helper that
//          turns a PID into a one-hot ready-mask bit.
// Ports:   none (package).

package youseios_pkg;

  localparam int PID_W    = 5;
  localparam int MAX_PROC = 32;

  typedef enum logic [2:0] {
    RUN  = 3'd0,
    SAVE = 3'd1,
    PICK = 3'd2,
    LOAD = 3'd3,
    IDLE = 3'd4
  } state_e;

  typedef logic [MAX_PROC-1:0] ready_mask_t;
  typedef logic [PID_W-1:0]    pid_t;

  function automatic ready_mask_t pid_bit(input pid_t pid);
    ready_mask_t m;
    m = '0;
    m[pid] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - cyclic search for the next ready PID after a given PID
//
// Purpose: combinational round-robin search. Starting strictly after cur_pid,
//          walks PIDs cur_pid+1 .. cur_pid+NUM_PROC modulo NUM_PROC and
//          returns the first one whose ready bit is set. The last candidate is
//          cur_pid itself, so a lone ready process finds itself.
// Ports:
//   ready_mask  in  32  ready bit per PID
//   cur_pid     in   5  PID to search after (must be < NUM_PROC)
//   next_pid    out  5  first ready PID found (cur_pid when none)
//   found       out  1  at least one ready bit was seen

module rr_arbiter
  import youseios_pkg::*;
#(
  parameter int NUM_PROC = 8
) (
  input  ready_mask_t ready_mask,
  input  pid_t        cur_pid,
  output pid_t        next_pid,
  output logic        found
);

  localparam logic [PID_W:0] NUM_L = (PID_W+1)'(NUM_PROC);

  logic [PID_W:0] idx;

  always_comb begin
    found    = 1'b0;
    next_pid = cur_pid;
    idx      = '0;
    for (int i = 1; i <= NUM_PROC; i++) begin
      // cur_pid < NUM_PROC, so one conditional subtract is a full modulo.
      idx = {1'b0, cur_pid} + (PID_W+1)'(i);
      if (idx >= NUM_L) begin
        idx = idx - NUM_L;
      end
      if (!found && ready_mask[idx[PID_W-1:0]]) begin
        found    = 1'b1;
        next_pid = idx[PID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// rtl/process_scheduler.sv - round-robin process scheduler with PCB save/load handshake
//
// Purpose: counts retired instructions against a time quantum; on expiry,
//          Yield or Halt it saves the running context, picks the next ready
//          PID round-robin and loads it, stalling the CPU meanwhile.
// Optional feature: SCHED_STATS_EN builds the Switch_Count register
//          (otherwise Switch_Count is tied to 0).
// Ports:
//   Clock         in   1  system clock, rising edge
//   Reset         in   1  asynchronous, active-low
//   Instr_done    in   1  CPU retired one instruction
//   Yield         in   1  running process yields (pulse)
//   Halt          in   1  running process terminated (pulse)
//   Create        in   1  mark Create_PID ready
//   Create_PID    in   5  PID to create (ignored when >= NUM_PROC)
//   PCB_Ack       in   1  PCB finished the current save/load
//   PID_out       out  5  PID used by the PCB for PC translation
//   Save_Req      out  1  save context of PID_out
//   Load_Req      out  1  load context of PID_out
//   CPU_Stall     out  1  high in every state but RUN
//   Idle          out  1  no process ready
//   Switch_Count  out 16  completed context switches

module process_scheduler
  import youseios_pkg::*;
#(
  parameter int NUM_PROC = 8,
  parameter int QUANTUM  = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Instr_done,
  input  logic             Yield,
  input  logic             Halt,
  input  logic             Create,
  input  logic [PID_W-1:0] Create_PID,
  input  logic             PCB_Ack,
  output logic [PID_W-1:0] PID_out,
  output logic             Save_Req,
  output logic             Load_Req,
  output logic             CPU_Stall,
  output logic             Idle,
  output logic [15:0]      Switch_Count
);

  localparam logic [PID_W:0] NUM_L  = (PID_W+1)'(NUM_PROC);
  localparam logic [15:0]    Q_LAST = 16'(QUANTUM - 1);

  state_e      state_q, state_d;
  pid_t        pid_q, pid_d;
  ready_mask_t ready_q, ready_d;
  logic [15:0] cnt_q, cnt_d;
  logic        save_q, save_d;
  logic        load_q, load_d;
  logic        stall_q, stall_d;
  logic        idle_q, idle_d;

  pid_t        arb_next;
  logic        arb_found;
  logic        create_ok;

  rr_arbiter #(
    .NUM_PROC (NUM_PROC)
  ) u_arb (
    .ready_mask (ready_q),
    .cur_pid    (pid_q),
    .next_pid   (arb_next),
    .found      (arb_found)
  );

  assign create_ok = Create && ({1'b0, Create_PID} < NUM_L);

  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    save_d  = save_q;
    load_d  = load_q;
    stall_d = stall_q;
    idle_d  = idle_q;

    case (state_q)
      RUN: begin
        if (Instr_done) begin
          cnt_d = cnt_q + 16'd1;
        end
        if (Halt) begin
          // Terminated process has no context worth saving.
          ready_d = ready_q & ~pid_bit(pid_q);
          state_d = PICK;
          stall_d = 1'b1;
        end else if (Yield || (Instr_done && cnt_q == Q_LAST)) begin
          state_d = SAVE;
          save_d  = 1'b1;
          stall_d = 1'b1;
        end
      end

      SAVE: begin
        if (PCB_Ack) begin
          save_d  = 1'b0;
          state_d = PICK;
        end
      end

      PICK: begin
        if (!arb_found) begin
          state_d = IDLE;
          idle_d  = 1'b1;
        end else if (arb_next == pid_q && ready_q[pid_q]) begin
          // Only the current process is ready: resume it, its context is live.
          state_d = RUN;
          stall_d = 1'b0;
          cnt_d   = '0;
        end else begin
          pid_d   = arb_next;
          state_d = LOAD;
          load_d  = 1'b1;
        end
      end

      LOAD: begin
        if (PCB_Ack) begin
          load_d  = 1'b0;
          state_d = RUN;
          stall_d = 1'b0;
          cnt_d   = '0;
        end
      end

      IDLE: begin
        if (create_ok) begin
          pid_d   = Create_PID;
          state_d = LOAD;
          load_d  = 1'b1;
          idle_d  = 1'b0;
        end
      end

      default: begin
        state_d = RUN;
        save_d  = 1'b0;
        load_d  = 1'b0;
        stall_d = 1'b0;
        idle_d  = 1'b0;
      end
    endcase

    // Applied after the state logic so a Create lands at the end of the cycle
    // and is never visible to a PICK evaluated in the same cycle.
    if (create_ok) begin
      ready_d = ready_d | pid_bit(Create_PID);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      pid_q   <= '0;
      ready_q <= ready_mask_t'(1);
      cnt_q   <= '0;
      save_q  <= 1'b0;
      load_q  <= 1'b0;
      stall_q <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      save_q  <= save_d;
      load_q  <= load_d;
      stall_q <= stall_d;
      idle_q  <= idle_d;
    end
  end

  assign PID_out   = pid_q;
  assign Save_Req  = save_q;
  assign Load_Req  = load_q;
  assign CPU_Stall = stall_q;
  assign Idle      = idle_q;

`ifdef SCHED_STATS_EN
  logic [15:0] sw_q, sw_d;

  always_comb begin
    sw_d = sw_q;
    if (state_q == LOAD && PCB_Ack) begin
      sw_d = sw_q + 16'd1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sw_q <= '0;
    end else begin
      sw_q <= sw_d;
    end
  end

  assign Switch_Count = sw_q;
`else
  assign Switch_Count = '0;
`endif

endmodule
